// File: rtl/free_list_if.sv
// ---------------------------------------------------------------------------
// free_list_if
// Bundles the rename-side, retire-side and checkpoint signals of the free list.
//
// Handshake semantics:
//   alloc:   a tag is consumed on a rising clk edge where alloc_req && alloc_ready
//            (and no checkpoint restore that cycle); alloc_preg is show-ahead and
//            only meaningful while alloc_ready is high.
//   release: release_valid qualifies release_preg for one cycle; there is no
//            back-pressure, a drop is reported one cycle later on release_err.
//
// Modports:
//   master - rename/ROB/branch-unit side (drives requests, observes status)
//   slave  - the free list itself
// ---------------------------------------------------------------------------
interface free_list_if #(
   parameter int TAG_W = 7,
   parameter int CNT_W = 8,
   parameter int ID_W  = 2
);
   logic             alloc_req;
   logic             alloc_ready;
   logic [TAG_W-1:0] alloc_preg;
   logic             release_valid;
   logic [TAG_W-1:0] release_preg;
   logic             ckpt_save;
   logic [ID_W-1:0]  ckpt_save_id;
   logic             ckpt_restore;
   logic [ID_W-1:0]  ckpt_restore_id;
   logic [CNT_W-1:0] free_count;
   logic             empty;
   logic             full;
   logic             release_err;

   modport master (
      output alloc_req, release_valid, release_preg,
             ckpt_save, ckpt_save_id, ckpt_restore, ckpt_restore_id,
      input  alloc_ready, alloc_preg, free_count, empty, full, release_err
   );

   modport slave (
      input  alloc_req, release_valid, release_preg,
             ckpt_save, ckpt_save_id, ckpt_restore, ckpt_restore_id,
      output alloc_ready, alloc_preg, free_count, empty, full, release_err
   );
endinterface

// File: rtl/free_list.sv
// ---------------------------------------------------------------------------
// free_list
// Circular FIFO of free physical-register tags. Rename pops from the head,
// ROB retirement pushes old destination tags at the tail, and per-branch
// checkpoints of the read side (head + allocation counter) let a mispredict
// hand every tag allocated on the wrong path back in a single cycle.
//
// Ports:
//   clk    - clock
//   reset  - asynchronous active-low reset
//   bus    - free_list_if.slave: alloc, release, checkpoint and status signals
// ---------------------------------------------------------------------------
module free_list #(
   parameter int NUM_PREGS = 128,
   parameter int NUM_AREGS = 32,
   parameter int NUM_CKPT  = 4
) (
   input  logic          clk,
   input  logic          reset,
   free_list_if.slave    bus
);
   localparam int DEPTH     = NUM_PREGS - 1;          // p0 is never free
   localparam int TAG_W     = $clog2(NUM_PREGS);
   localparam int CNT_W     = TAG_W + 1;
   localparam int ID_W      = $clog2(NUM_CKPT);
   localparam int INIT_FREE = NUM_PREGS - NUM_AREGS;  // tags not mapped at reset

   typedef struct packed {
      logic [TAG_W-1:0] head;
      logic [7:0]       alloc_cnt;
   } ckpt_t;

   logic [TAG_W-1:0] r_mem [DEPTH];
   logic [TAG_W-1:0] r_head;
   logic [TAG_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic [7:0]       r_alloc_cnt;
   ckpt_t            r_ckpt [NUM_CKPT];
   logic             r_release_err;

   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_rel_drop;
   logic [TAG_W-1:0] w_head_inc;
   logic [TAG_W-1:0] w_tail_inc;
   logic [TAG_W-1:0] w_head_after_pop;
   logic [7:0]       w_cnt_after_pop;
   ckpt_t            w_rs;
   logic [7:0]       w_rollback;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(DEPTH));

   // Restore owns the read side for the cycle, so a pop is suppressed there.
   assign w_pop      = bus.alloc_req && !w_empty && !bus.ckpt_restore;
   assign w_push     = bus.release_valid && (bus.release_preg != '0) && !w_full;
   assign w_rel_drop = bus.release_valid && (bus.release_preg != '0) && w_full;

   // DEPTH is not a power of two, so the wrap is an explicit compare.
   assign w_head_inc = (r_head == TAG_W'(DEPTH - 1)) ? '0 : r_head + 1'b1;
   assign w_tail_inc = (r_tail == TAG_W'(DEPTH - 1)) ? '0 : r_tail + 1'b1;

   // A checkpoint taken alongside a pop records the post-pop read side, so
   // that allocation stays on the pre-branch path.
   assign w_head_after_pop = w_pop ? w_head_inc : r_head;
   assign w_cnt_after_pop  = r_alloc_cnt + 8'(w_pop);

   // Slot contents are read before any same-cycle save updates them.
   assign w_rs       = r_ckpt[bus.ckpt_restore_id];
   assign w_rollback = r_alloc_cnt - w_rs.alloc_cnt;   // mod-256 tags handed back

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= (i < INIT_FREE) ? TAG_W'(NUM_AREGS + i) : '0;
         end
         r_head        <= '0;
         r_tail        <= TAG_W'(INIT_FREE);
         r_count       <= CNT_W'(INIT_FREE);
         r_alloc_cnt   <= '0;
         r_release_err <= 1'b0;
         for (int k = 0; k < NUM_CKPT; k++) begin
            r_ckpt[k] <= '0;
         end
      end else begin
         r_release_err <= w_rel_drop;

         // Write side is independent of restore: tail only moves on push.
         if (w_push) begin
            r_mem[r_tail] <= bus.release_preg;
            r_tail        <= w_tail_inc;
         end

         if (bus.ckpt_restore) begin
            r_head      <= w_rs.head;
            r_alloc_cnt <= w_rs.alloc_cnt;
            r_count     <= r_count + CNT_W'(w_rollback) + CNT_W'(w_push);
         end else begin
            r_head      <= w_head_after_pop;
            r_alloc_cnt <= w_cnt_after_pop;
            r_count     <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (bus.ckpt_save) begin
               r_ckpt[bus.ckpt_save_id] <= '{head: w_head_after_pop,
                                             alloc_cnt: w_cnt_after_pop};
            end
         end
      end
   end

   // Show-ahead read from registered state only; no bypass from release.
   assign bus.alloc_ready = !w_empty;
   assign bus.alloc_preg  = r_mem[r_head];
   assign bus.free_count  = r_count;
   assign bus.empty       = w_empty;
   assign bus.full        = w_full;
   assign bus.release_err = r_release_err;

endmodule

// File: tb/tb_free_list.sv
// ---------------------------------------------------------------------------
// tb_free_list
// Directed scenarios plus randomized traffic for free_list. The reference
// model keeps the free tags as a queue, logs every allocated tag in order, and
// treats a checkpoint as "number of allocations so far"; a restore pushes the
// most recent allocations back onto the front of the queue.
// ---------------------------------------------------------------------------
module tb_free_list;
   localparam int TAG_W = 7;
   localparam int CNT_W = 8;
   localparam int ID_W  = 2;

   logic clk = 1'b0;
   logic reset;

   free_list_if #(.TAG_W(TAG_W), .CNT_W(CNT_W), .ID_W(ID_W)) bus ();

   free_list #(.NUM_PREGS(128), .NUM_AREGS(32), .NUM_CKPT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // ---------------- reference model ----------------
   logic [TAG_W-1:0] m_q[$];      // free tags, head at index 0
   logic [TAG_W-1:0] m_log[$];    // allocated tags, oldest first
   int               m_total;     // allocations so far
   int               m_ck_total[4];
   bit               m_ck_valid[4];
   bit               m_err;

   task automatic model_reset();
      m_q.delete();
      for (int i = 0; i < 96; i++) m_q.push_back(TAG_W'(32 + i));
      m_log.delete();
      m_total = 0;
      for (int k = 0; k < 4; k++) begin
         m_ck_total[k] = 0;
         m_ck_valid[k] = 1'b1;
      end
      m_err = 1'b0;
   endtask

   task automatic model_step(input bit req, input bit rv, input logic [TAG_W-1:0] rp,
                             input bit sv, input int sid, input bit rs, input int rid);
      bit full_now;
      bit empty_now;
      bit push_ok;
      int n;
      full_now  = (m_q.size() == 127);
      empty_now = (m_q.size() == 0);
      push_ok   = rv && (rp != 0) && !full_now;
      m_err     = rv && (rp != 0) && full_now;
      if (rs) begin
         n = m_total - m_ck_total[rid];
         for (int k = 0; k < n; k++) m_q.push_front(m_log.pop_back());
         m_total = m_ck_total[rid];
         for (int k = 0; k < 4; k++)
            if (m_ck_total[k] > m_total) m_ck_valid[k] = 1'b0;
      end else begin
         if (req && !empty_now) begin
            m_log.push_back(m_q.pop_front());
            m_total++;
         end
         if (sv) begin
            m_ck_total[sid] = m_total;
            m_ck_valid[sid] = 1'b1;
         end
      end
      if (push_ok) m_q.push_back(rp);
   endtask

   // ---------------- driver ----------------
   task automatic clear_inputs();
      bus.alloc_req       = 1'b0;
      bus.release_valid   = 1'b0;
      bus.release_preg    = '0;
      bus.ckpt_save       = 1'b0;
      bus.ckpt_save_id    = '0;
      bus.ckpt_restore    = 1'b0;
      bus.ckpt_restore_id = '0;
   endtask

   // One clock: present inputs, take the edge, sample 1 time unit later.
   task automatic drive(input bit req, input bit rv, input logic [TAG_W-1:0] rp,
                        input bit sv, input int sid, input bit rs, input int rid);
      bus.alloc_req       = req;
      bus.release_valid   = rv;
      bus.release_preg    = rp;
      bus.ckpt_save       = sv;
      bus.ckpt_save_id    = ID_W'(sid);
      bus.ckpt_restore    = rs;
      bus.ckpt_restore_id = ID_W'(rid);
      @(posedge clk);
      #1;
      model_step(req, rv, rp, sv, sid, rs, rid);
      clear_inputs();
   endtask

   task automatic apply_reset();
      clear_inputs();
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      apply_reset();
      n_checks++; if (bus.alloc_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b want 1", bus.alloc_ready); end
      n_checks++; if (bus.alloc_preg !== 7'd32) begin n_errors++; $display("FAIL reset_preg got %0d want 32", bus.alloc_preg); end
      n_checks++; if (bus.free_count !== 8'd96) begin n_errors++; $display("FAIL reset_count got %0d want 96", bus.free_count); end
      n_checks++; if (bus.empty !== 1'b0) begin n_errors++; $display("FAIL reset_empty got %b want 0", bus.empty); end
      n_checks++; if (bus.full !== 1'b0) begin n_errors++; $display("FAIL reset_full got %b want 0", bus.full); end
      n_checks++; if (bus.release_err !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b want 0", bus.release_err); end
   endtask

   task automatic test_drain();
      apply_reset();
      for (int i = 0; i < 96; i++) begin
         n_checks++;
         if (bus.alloc_preg !== TAG_W'(32 + i) || bus.alloc_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL drain_seq[%0d] got preg %0d ready %b want preg %0d ready 1", i, bus.alloc_preg, bus.alloc_ready, 32 + i);
         end
         drive(1, 0, 0, 0, 0, 0, 0);
      end
      n_checks++; if (bus.empty !== 1'b1) begin n_errors++; $display("FAIL drain_empty got %b want 1", bus.empty); end
      n_checks++; if (bus.alloc_ready !== 1'b0) begin n_errors++; $display("FAIL drain_ready got %b want 0", bus.alloc_ready); end
      n_checks++; if (bus.free_count !== 8'd0) begin n_errors++; $display("FAIL drain_count got %0d want 0", bus.free_count); end
      drive(1, 0, 0, 0, 0, 0, 0);
      n_checks++; if (bus.free_count !== 8'd0 || bus.empty !== 1'b1) begin n_errors++; $display("FAIL empty_req count %0d empty %b want 0 1", bus.free_count, bus.empty); end
      // Release into an empty list with a concurrent request: no bypass.
      drive(1, 1, 7'd5, 0, 0, 0, 0);
      n_checks++; if (bus.alloc_ready !== 1'b1) begin n_errors++; $display("FAIL nobypass_ready got %b want 1", bus.alloc_ready); end
      n_checks++; if (bus.alloc_preg !== 7'd5) begin n_errors++; $display("FAIL nobypass_preg got %0d want 5", bus.alloc_preg); end
      n_checks++; if (bus.free_count !== 8'd1) begin n_errors++; $display("FAIL nobypass_count got %0d want 1", bus.free_count); end
   endtask

   task automatic test_ckpt();
      // Basic save / restore.
      apply_reset();
      repeat (3) drive(1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 1, 0, 0);
      repeat (4) drive(1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 1);
      n_checks++; if (bus.alloc_preg !== 7'd35) begin n_errors++; $display("FAIL restore_preg got %0d want 35", bus.alloc_preg); end
      n_checks++; if (bus.free_count !== 8'd93) begin n_errors++; $display("FAIL restore_count got %0d want 93", bus.free_count); end

      // Release lands on the restore cycle, with a suppressed pop.
      apply_reset();
      repeat (3) drive(1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 1, 0, 0);
      repeat (4) drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 7'd7, 0, 0, 1, 1);
      n_checks++; if (bus.free_count !== 8'd94) begin n_errors++; $display("FAIL restore_rel_count got %0d want 94", bus.free_count); end
      n_checks++; if (bus.alloc_preg !== 7'd35) begin n_errors++; $display("FAIL restore_rel_preg got %0d want 35", bus.alloc_preg); end
      repeat (93) drive(1, 0, 0, 0, 0, 0, 0);
      n_checks++; if (bus.alloc_preg !== 7'd7 || bus.free_count !== 8'd1) begin n_errors++; $display("FAIL tail_p7 got preg %0d count %0d want 7 1", bus.alloc_preg, bus.free_count); end

      // Save together with a pop: the popped tag is pre-branch.
      apply_reset();
      drive(1, 0, 0, 1, 2, 0, 0);
      repeat (2) drive(1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 2);
      n_checks++; if (bus.alloc_preg !== 7'd33 || bus.free_count !== 8'd95) begin n_errors++; $display("FAIL save_with_pop got preg %0d count %0d want 33 95", bus.alloc_preg, bus.free_count); end

      // Save and restore the same slot: restore sees the old contents.
      apply_reset();
      drive(1, 0, 0, 1, 3, 0, 0);          // slot3 = after 1 alloc
      repeat (4) drive(1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 3, 1, 3);
      n_checks++; if (bus.alloc_preg !== 7'd33 || bus.free_count !== 8'd95) begin n_errors++; $display("FAIL save_restore_same got preg %0d count %0d want 33 95", bus.alloc_preg, bus.free_count); end
      repeat (2) drive(1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 3);
      n_checks++; if (bus.alloc_preg !== 7'd33 || bus.free_count !== 8'd95) begin n_errors++; $display("FAIL save_ignored got preg %0d count %0d want 33 95", bus.alloc_preg, bus.free_count); end
   endtask

   task automatic test_release_edges();
      apply_reset();
      drive(0, 1, 7'd0, 0, 0, 0, 0);
      n_checks++; if (bus.free_count !== 8'd96 || bus.release_err !== 1'b0) begin n_errors++; $display("FAIL rel_p0 got count %0d err %b want 96 0", bus.free_count, bus.release_err); end
      for (int t = 1; t < 32; t++) drive(0, 1, TAG_W'(t), 0, 0, 0, 0);
      n_checks++; if (bus.free_count !== 8'd127 || bus.full !== 1'b1) begin n_errors++; $display("FAIL fill got count %0d full %b want 127 1", bus.free_count, bus.full); end
      drive(0, 1, 7'd1, 0, 0, 0, 0);
      n_checks++; if (bus.release_err !== 1'b1 || bus.free_count !== 8'd127) begin n_errors++; $display("FAIL rel_full got err %b count %0d want 1 127", bus.release_err, bus.free_count); end
      drive(0, 0, 0, 0, 0, 0, 0);
      n_checks++; if (bus.release_err !== 1'b0) begin n_errors++; $display("FAIL err_pulse got %b want 0", bus.release_err); end
      // Pop and release while full: pop proceeds, release is dropped.
      drive(1, 1, 7'd2, 0, 0, 0, 0);
      n_checks++; if (bus.release_err !== 1'b1 || bus.free_count !== 8'd126 || bus.alloc_preg !== 7'd33) begin n_errors++; $display("FAIL pop_full got err %b count %0d preg %0d want 1 126 33", bus.release_err, bus.free_count, bus.alloc_preg); end
   endtask

   task automatic test_wrap();
      logic [TAG_W-1:0] pool[$];
      logic [TAG_W-1:0] tag;
      apply_reset();
      for (int t = 1; t < 32; t++) pool.push_back(TAG_W'(t));
      for (int i = 0; i < 200; i++) begin
         n_checks++;
         if (bus.alloc_preg !== m_q[0] || bus.free_count !== 8'd96) begin
            n_errors++;
            $display("FAIL wrap[%0d] got preg %0d count %0d want %0d 96", i, bus.alloc_preg, bus.free_count, m_q[0]);
         end
         tag = m_q[0];
         drive(1, 1, pool.pop_front(), 0, 0, 0, 0);
         pool.push_back(tag);
      end
   endtask

   task automatic test_random_release();
      logic [TAG_W-1:0] pool[$];
      logic [TAG_W-1:0] rp;
      bit req;
      bit rv;
      int idx;
      apply_reset();
      for (int t = 1; t < 32; t++) pool.push_back(TAG_W'(t));
      for (int i = 0; i < 500; i++) begin
         req = ($urandom_range(0, 99) < 50);
         rv  = ($urandom_range(0, 99) < 50);
         rp  = '0;
         if (rv && pool.size() != 0 && $urandom_range(0, 9) != 0) begin
            idx = $urandom_range(0, pool.size() - 1);
            rp  = pool[idx];
            pool.delete(idx);
         end
         if (req && m_q.size() != 0) pool.push_back(m_q[0]);
         drive(req, rv, rp, 0, 0, 0, 0);
         n_checks++;
         if (bus.free_count !== CNT_W'(m_q.size()) || bus.empty !== (m_q.size() == 0) ||
             bus.full !== (m_q.size() == 127) || bus.alloc_ready !== (m_q.size() != 0) ||
             bus.release_err !== m_err || (m_q.size() != 0 && bus.alloc_preg !== m_q[0])) begin
            n_errors++;
            $display("FAIL rand_rel[%0d] got count %0d preg %0d err %b want count %0d preg %0d err %b",
                     i, bus.free_count, bus.alloc_preg, bus.release_err, m_q.size(),
                     (m_q.size() != 0) ? m_q[0] : 7'd0, m_err);
         end
      end
   endtask

   task automatic test_random_ckpt();
      bit req;
      bit sv;
      bit rs;
      bit rv;
      int sid;
      int rid;
      int cand[$];
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         req = ($urandom_range(0, 99) < 75);
         sv  = ($urandom_range(0, 99) < 20);
         sid = $urandom_range(0, 3);
         rv  = ($urandom_range(0, 99) < 10);   // p0 only: must be dropped
         rs  = 1'b0;
         rid = 0;
         cand.delete();
         for (int k = 0; k < 4; k++)
            if (m_ck_valid[k] && m_ck_total[k] <= m_total) cand.push_back(k);
         if (cand.size() != 0 && $urandom_range(0, 99) < 12) begin
            rs  = 1'b1;
            rid = cand[$urandom_range(0, cand.size() - 1)];
         end
         drive(req, rv, 7'd0, sv, sid, rs, rid);
         n_checks++;
         if (bus.free_count !== CNT_W'(m_q.size()) || bus.empty !== (m_q.size() == 0) ||
             bus.alloc_ready !== (m_q.size() != 0) || bus.release_err !== 1'b0 ||
             (m_q.size() != 0 && bus.alloc_preg !== m_q[0])) begin
            n_errors++;
            $display("FAIL rand_ckpt[%0d] got count %0d preg %0d want count %0d preg %0d",
                     i, bus.free_count, bus.alloc_preg, m_q.size(), (m_q.size() != 0) ? m_q[0] : 7'd0);
         end
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      repeat (5) drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 0, 0, 0);
      drive(1, 1, 7'd3, 1, 2, 0, 0);
      #2;
      reset = 1'b0;                         // asynchronous, between edges
      #1;
      n_checks++; if (bus.free_count !== 8'd96 || bus.alloc_preg !== 7'd32 || bus.release_err !== 1'b0) begin n_errors++; $display("FAIL async_reset got count %0d preg %0d err %b want 96 32 0", bus.free_count, bus.alloc_preg, bus.release_err); end
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 1, 2);           // cleared checkpoint: back to head 0
      n_checks++; if (bus.free_count !== 8'd96 || bus.alloc_preg !== 7'd32) begin n_errors++; $display("FAIL ckpt_cleared got count %0d preg %0d want 96 32", bus.free_count, bus.alloc_preg); end
   endtask

   initial begin
      reset = 1'b0;
      clear_inputs();
      test_reset();
      test_drain();
      test_ckpt();
      test_release_edges();
      test_wrap();
      test_random_release();
      test_random_ckpt();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular FIFO of free physical-register tags, sitting between rename and the ROB commit path.
- Rename pops one tag per cycle for a new destination mapping.
- ROB retirement pushes back the retired instruction's old destination tag (pd_old).
- Per-branch checkpoints of the read side allow single-cycle recovery of all tags allocated on a mispredicted path.

Parameters:
- NUM_PREGS, 128, total physical registers. Tag width is clog2(NUM_PREGS) = 7.
- NUM_AREGS, 32, architectural registers. p0..p31 are mapped at reset.
- NUM_CKPT, 4, number of checkpoint slots (outstanding branches).
- DEPTH, NUM_PREGS-1 (127), FIFO slots. p0 is never free.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- alloc_req  in  1  rename requests one tag this cycle
- alloc_ready  out  1  list not empty; alloc_preg is valid
- alloc_preg  out  7  tag at head (show-ahead)
- release_valid  in  1  ROB retire valid
- release_preg  in  7  retired pd_old tag
- ckpt_save  in  1  snapshot read side into slot ckpt_save_id
- ckpt_save_id  in  2  slot index
- ckpt_restore  in  1  mispredict recovery from slot ckpt_restore_id
- ckpt_restore_id  in  2  slot index
- free_count  out  8  current occupancy, 0..127
- empty  out  1  free_count==0
- full  out  1  free_count==DEPTH
- release_err  out  1  pulse: release dropped because list full (protocol violation)

Behaviour:
- Reset (reset==0, async):
  - mem[i] = 32+i for i = 0..95; other slots don't-care.
  - head=0, tail=96, free_count=96, alloc_cnt=0.
  - All checkpoint slots cleared to head=0, alloc_cnt=0.
  - Outputs after reset: alloc_ready=1, alloc_preg=32, empty=0, full=0, release_err=0.
- Pointers: head and tail wrap modulo DEPTH (126 -> 0). They are not power-of-2 and need an explicit compare.
- alloc_ready = !empty. alloc_preg = mem[head] combinationally, read from registered state only. There is no same-cycle bypass from release.
- Pop fires when alloc_req && alloc_ready && !ckpt_restore:
  - head advances by 1.
  - alloc_cnt (8-bit, free-running, wraps at 256) increments.
  - alloc_req while empty is ignored, with no state change.
- Push fires when release_valid && release_preg!=0 && !full:
  - mem[tail] = release_preg, tail advances by 1.
  - Release of p0 is silently dropped.
  - Release while full is dropped and release_err=1 for that cycle (registered, 1-cycle pulse).
- free_count next = free_count + push - pop, except during restore (see below).
- ckpt_save: slot[id] captures {head, alloc_cnt} as they stand after this cycle's pop. A same-cycle allocation therefore belongs to the pre-branch path.
- ckpt_restore (priority over alloc and save):
  - head = slot[rid].head, alloc_cnt = slot[rid].alloc_cnt.
  - free_count = free_count + ((alloc_cnt - slot.alloc_cnt) mod 256) + push.
  - A release in the same cycle is still applied; tail is never touched by restore.
  - Save in the same cycle is ignored. Pop in the same cycle is suppressed.
- Save and restore to the same slot in one cycle: restore uses the old slot contents.
- Reset mid-operation: all state returns to reset values immediately. No pending releases are retained.

Test Plan:
- Reset then 96 back-to-back pops -> alloc_preg sequence is 32..127; after the last pop empty=1, alloc_ready=0, free_count=0; a further alloc_req leaves head unchanged.
- From empty, release p5 with alloc_req high in the same cycle -> no pop that cycle; next cycle alloc_ready=1, alloc_preg=5, free_count=1.
- Pop 3 (32,33,34), ckpt_save id=1, pop 4 more, ckpt_restore id=1 -> alloc_preg=35, free_count=93.
- Same as above, but a release of p7 lands on the restore cycle -> free_count=94; p7 is appended at the tail and reappears after 93 pops.
- Release p0 -> ignored, free_count unchanged. Release while full (127 entries) -> release_err pulses 1 cycle, count stays 127.
- Head wrap: cycle 200 pop/push pairs -> head/tail wrap past 126, tags are returned in FIFO order, and free_count stays constant.
